pixel_frame_buffer: RTL

//  Sits directly downstream of the crop/downsample stage. Captures one
//  28x28 frame of 8-bit grey samples (one per input strobe, raster order)

---
 rtl/pixel_frame_buffer.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_buffer.sv
// ---------------------------------------------------------------------------
// pixel_frame_buffer
//
// Captures one IMG_W x IMG_H frame of DATA_W-bit grey samples (raster order,
// one per iDVAL strobe) into on-chip RAM, then streams it out byte-by-byte
// over a valid/ready handshake. Sequencing is IDLE -> ARM -> FILL -> FULL ->
// DRAIN -> IDLE.
//
// Build option:
//   PIXEL_FRAME_BUFFER_HEADER_EN  when defined, the drained stream is
//                                 prefixed by 8'hA5, IMG_W, IMG_H.
//
// Ports:
//   iCLK          clock, all logic on the rising edge
//   iRST          asynchronous active-high reset
//   buf_rst       synchronous soft reset, overrides every other input
//   iCAP_REQ      pulse, arms capture of the next frame (IDLE only)
//   iFRAME_START  pulse, a new camera frame starts (ARM / FILL)
//   iDVAL, iDATA  sample strobe and value
//   oTX_DATA      byte to the consumer
//   oTX_VALID     oTX_DATA valid
//   iTX_READY     consumer accepts the byte
//   oFULL         frame captured and not yet fully drained
//   oBUSY         FSM not in IDLE (registered)
//   oDONE         one-cycle pulse after the last byte was accepted
//   oDBG_STATE    current FSM state, for debug / checkers
//
// Handshake: a byte transfers on a rising edge where oTX_VALID && iTX_READY.
// oTX_VALID never depends combinationally on iTX_READY; while oTX_VALID is
// high and iTX_READY is low, oTX_DATA holds. After every transfer oTX_VALID
// is low for exactly one cycle while the next byte is read from RAM.
// ---------------------------------------------------------------------------
module pixel_frame_buffer #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              buf_rst,
  input  logic              iCAP_REQ,
  input  logic              iFRAME_START,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  output logic [DATA_W-1:0] oTX_DATA,
  output logic              oTX_VALID,
  input  logic              iTX_READY,
  output logic              oFULL,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [2:0]        oDBG_STATE
);

  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);

`ifdef PIXEL_FRAME_BUFFER_HEADER_EN
  localparam int HDR_LEN = 3;
`else
  localparam int HDR_LEN = 0;
`endif

  // Read counter spans the whole stream, header included.
  localparam int RW = $clog2(N + HDR_LEN);

  localparam logic [AW-1:0] WR_LAST = AW'(N - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(N + HDR_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_FILL  = 3'd2,
    S_FULL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Frame storage, never cleared by reset.
  logic [DATA_W-1:0] r_mem [0:N-1];

  state_t            r_state;
  logic [AW-1:0]     r_wr;
  logic [RW-1:0]     r_rd;
  logic              r_vld;
  logic              r_full;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_tx_data;

  state_t            w_state_nxt;
  logic [AW-1:0]     w_wr_nxt;
  logic [RW-1:0]     w_rd_nxt;
  logic              w_vld_nxt;
  logic              w_full_nxt;
  logic              w_done_nxt;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic              w_load;
  logic [AW-1:0]     w_mem_addr;
  logic [DATA_W-1:0] w_rd_byte;

  // ---------------------------------------------------------------------
  // Byte selected by the read counter: header bytes first (if enabled),
  // then the pixel at the matching RAM address.
  // ---------------------------------------------------------------------
`ifdef PIXEL_FRAME_BUFFER_HEADER_EN
  always_comb begin
    w_mem_addr = '0;
    if (r_rd >= RW'(HDR_LEN)) begin
      w_mem_addr = AW'(r_rd - RW'(HDR_LEN));
    end
    w_rd_byte = r_mem[w_mem_addr];
    case (r_rd)
      RW'(0):  w_rd_byte = DATA_W'(8'hA5);
      RW'(1):  w_rd_byte = DATA_W'(IMG_W);
      RW'(2):  w_rd_byte = DATA_W'(IMG_H);
      default: w_rd_byte = r_mem[w_mem_addr];
    endcase
  end
`else
  always_comb begin
    w_mem_addr = AW'(r_rd);
    w_rd_byte  = r_mem[w_mem_addr];
  end
`endif

  // ---------------------------------------------------------------------
  // Next-state and datapath control.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr;
    w_rd_nxt    = r_rd;
    w_vld_nxt   = r_vld;
    w_full_nxt  = r_full;
    w_done_nxt  = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_wr;
    w_load      = 1'b0;

    if (buf_rst) begin
      w_state_nxt = S_IDLE;
      w_wr_nxt    = '0;
      w_rd_nxt    = '0;
      w_vld_nxt   = 1'b0;
      w_full_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_wr_nxt = '0;
          w_rd_nxt = '0;
          if (iCAP_REQ) begin
            w_state_nxt = S_ARM;
          end
        end

        S_ARM: begin
          if (iFRAME_START) begin
            w_state_nxt = S_FILL;
            w_wr_nxt    = '0;
            // A sample arriving together with the frame start is pixel 0.
            if (iDVAL) begin
              w_we     = 1'b1;
              w_waddr  = '0;
              w_wr_nxt = AW'(1);
            end
          end
        end

        S_FILL: begin
          if (iFRAME_START) begin
            // Resync: drop the partial frame and restart at pixel 0.
            w_wr_nxt = '0;
            if (iDVAL) begin
              w_we     = 1'b1;
              w_waddr  = '0;
              w_wr_nxt = AW'(1);
            end
          end else if (iDVAL) begin
            w_we = 1'b1;
            if (r_wr == WR_LAST) begin
              w_state_nxt = S_FULL;
              w_full_nxt  = 1'b1;
              w_wr_nxt    = '0;
            end else begin
              w_wr_nxt = r_wr + AW'(1);
            end
          end
        end

        S_FULL: begin
          // Fetch stream byte 0; it is presented on the first DRAIN cycle.
          w_load      = 1'b1;
          w_vld_nxt   = 1'b1;
          w_rd_nxt    = '0;
          w_state_nxt = S_DRAIN;
        end

        S_DRAIN: begin
          if (r_vld) begin
            if (iTX_READY) begin
              w_vld_nxt = 1'b0;
              if (r_rd == RD_LAST) begin
                w_state_nxt = S_IDLE;
                w_full_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_rd_nxt    = '0;
              end else begin
                w_rd_nxt = r_rd + RW'(1);
              end
            end
          end else begin
            // Bubble cycle: read the byte addressed by the new counter.
            w_load    = 1'b1;
            w_vld_nxt = 1'b1;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_wr_nxt    = '0;
          w_rd_nxt    = '0;
          w_vld_nxt   = 1'b0;
          w_full_nxt  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State and control registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_wr      <= '0;
      r_rd      <= '0;
      r_vld     <= 1'b0;
      r_full    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_vld   <= w_vld_nxt;
      r_full  <= w_full_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      if (buf_rst) begin
        r_tx_data <= '0;
      end else if (w_load) begin
        r_tx_data <= w_rd_byte;
      end
    end
  end

  // Frame RAM write port. Writes only happen in ARM/FILL, which the FSM
  // cannot be in while reset is held.
  always_ff @(posedge iCLK) begin
    if (w_we) begin
      r_mem[w_waddr] <= iDATA;
    end
  end

  assign oTX_DATA   = r_tx_data;
  assign oTX_VALID  = r_vld;
  assign oFULL      = r_full;
  assign oBUSY      = r_busy;
  assign oDONE      = r_done;
  assign oDBG_STATE = r_state;

endmodule
